// File: rtl/dsram_responder_pkg.sv
// Shared types for the data-SRAM responder: size codes, queue entry layout
// and the control state encoding.
package dsram_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int ADDR_FIELD_W = 32;
    localparam int DATA_FIELD_W = 32;
    localparam int STRB_FIELD_W = 4;
    localparam int SIZE_FIELD_W = 2;
    localparam int CNT_W        = 4;

    typedef struct packed {
        logic                    wr;
        logic [SIZE_FIELD_W-1:0] size;
        logic [STRB_FIELD_W-1:0] wstrb;
        logic [ADDR_FIELD_W-1:0] addr;
        logic [DATA_FIELD_W-1:0] wdata;
    } req_entry_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    // Wait counters stop at zero; zero means "head may complete now".
    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

endpackage

// File: rtl/dsram_if.sv
// CPU-side request/response bundle of the data-SRAM responder.
interface dsram_if;
    import dsram_responder_pkg::*;

    logic                    req;
    logic                    wr;
    logic [SIZE_FIELD_W-1:0] size;
    logic [STRB_FIELD_W-1:0] wstrb;
    logic [ADDR_FIELD_W-1:0] addr;
    logic [DATA_FIELD_W-1:0] wdata;
    logic                    addr_ok;
    logic                    data_ok;
    logic [DATA_FIELD_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/dsram_req_fifo.sv
// Two-entry request queue; slot 0 is always the head. Push and pop may
// happen in the same cycle.
module dsram_req_fifo
    import dsram_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  req_entry_t din,
    output req_entry_t head,
    output logic       full,
    output logic       empty
);

    req_entry_t slot [2];
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = slot[0];
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~full;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Payload slots carry no reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_pop) begin
            slot[0] <= full ? slot[1] : din;
        end else if (do_push && empty) begin
            slot[0] <= din;
        end
        if (do_push && !do_pop && (count == 2'd1)) begin
            slot[1] <= din;
        end
    end

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM responder: queues up to two CPU requests, completes them in order
// no sooner than LATENCY cycles after acceptance, one completion per cycle.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no request pending, always ready to accept
// ST_BUSY  | one or two requests pending in the queue
module dsram_responder
    import dsram_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic     clk,
    input  logic     reset,
    dsram_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    req_entry_t        new_entry;
    req_entry_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              addr_ok;
    logic              data_ok;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  head_rem;
    logic [CNT_W-1:0]  tail_rem;
    logic [ADDR_W-1:0] head_idx;
    logic [31:0]       mem [2**ADDR_W];
    logic              unused_fields;

    assign new_entry = '{
        wr:    bus.wr,
        size:  bus.size,
        wstrb: bus.wstrb,
        addr:  bus.addr,
        wdata: bus.wdata
    };

    assign push = bus.req & addr_ok;
    assign pop  = data_ok;

    dsram_req_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (new_entry),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs depend only on registered state and reset, never on req.
    always_comb begin
        state_nxt = state;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        case (state)
            ST_EMPTY: begin
                addr_ok = ~reset;
                if (bus.req && !reset) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                addr_ok = ~reset & ~fifo_full;
                data_ok = ~reset & ~fifo_empty & (head_rem == '0);
                if (data_ok && !fifo_full && !bus.req) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // head_rem: cycles the head must still wait. tail_rem ages the second
    // entry so that, once promoted, it completes at max(accept+LATENCY, prev+1).
    always_ff @(posedge clk) begin
        if (reset) begin
            head_rem <= '0;
            tail_rem <= '0;
        end else begin
            if (pop) begin
                if (fifo_full) begin
                    head_rem <= dec_sat(tail_rem);
                end else if (push) begin
                    head_rem <= LAT_LOAD;
                end else begin
                    head_rem <= '0;
                end
            end else if (push && fifo_empty) begin
                head_rem <= LAT_LOAD;
            end else begin
                head_rem <= dec_sat(head_rem);
            end

            if (push && !pop && !fifo_empty) begin
                tail_rem <= LAT_LOAD;
            end else begin
                tail_rem <= dec_sat(tail_rem);
            end
        end
    end

    assign head_idx = head.addr[ADDR_W+1:2];

    // Writes commit at the edge closing their data_ok cycle; no reset on purpose.
    always_ff @(posedge clk) begin
        if (data_ok && head.wr) begin
            for (int i = 0; i < STRB_FIELD_W; i++) begin
                if (head.wstrb[i]) begin
                    mem[head_idx][8*i +: 8] <= head.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.addr_ok = addr_ok;
    assign bus.data_ok = data_ok;
    assign bus.rdata   = (data_ok && !head.wr) ? mem[head_idx] : '0;

    // Size and sub-word/high address bits are recorded but do not steer the array.
    assign unused_fields = ^{head.size, head.addr[ADDR_FIELD_W-1:ADDR_W+2], head.addr[1:0]};

endmodule

// File: tb/tb_dsram_responder.sv
// Drives three responders (LATENCY 2, 1, 4) with one stimulus stream and
// checks each against a completion-schedule model every cycle.
module tb_dsram_responder;
    import dsram_responder_pkg::*;

    localparam int NI    = 3;
    localparam int TB_AW = 10;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic        aok [NI];
    logic        dok [NI];
    logic [31:0] rdv [NI];

    always #5 clk = ~clk;

    dsram_if bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT_G = lat_of(g);
        assign bus[g].req   = req;
        assign bus[g].wr    = wr;
        assign bus[g].size  = size;
        assign bus[g].wstrb = wstrb;
        assign bus[g].addr  = addr;
        assign bus[g].wdata = wdata;
        assign aok[g] = bus[g].addr_ok;
        assign dok[g] = bus[g].data_ok;
        assign rdv[g] = bus[g].rdata;
        dsram_responder #(.ADDR_W(TB_AW), .LATENCY(LAT_G)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Model: each pending request carries the cycle it must complete in.
    int          pcnt [NI];
    int          pdue [NI][2];
    logic        pwr  [NI][2];
    logic [3:0]  pst  [NI][2];
    logic [31:0] padr [NI][2];
    logic [31:0] pdat [NI][2];
    int          last_due [NI];
    logic [31:0] mmem [NI][1024];
    int          mcyc = 0;
    logic        e_aok;
    logic        e_dok;
    logic [31:0] e_rd;
    int          due;
    int          widx;

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            e_aok = !reset && (pcnt[k] < 2);
            e_dok = !reset && (pcnt[k] > 0) && (pdue[k][0] == mcyc);
            e_rd  = 32'd0;
            widx  = (pcnt[k] > 0) ? int'(padr[k][0][TB_AW+1:2]) : 0;
            if (e_dok && !pwr[k][0]) e_rd = mmem[k][widx];
            chk($sformatf("addr_ok[%0d]@%0d", k, mcyc), {31'd0, aok[k]}, {31'd0, e_aok});
            chk($sformatf("data_ok[%0d]@%0d", k, mcyc), {31'd0, dok[k]}, {31'd0, e_dok});
            chk($sformatf("rdata[%0d]@%0d", k, mcyc), rdv[k], e_rd);
            if (reset) begin
                pcnt[k]     = 0;
                last_due[k] = -1000;
            end else begin
                if (e_dok) begin
                    if (pwr[k][0]) begin
                        for (int i = 0; i < 4; i++)
                            if (pst[k][0][i]) mmem[k][widx][8*i +: 8] = pdat[k][0][8*i +: 8];
                    end
                    pdue[k][0] = pdue[k][1];
                    pwr[k][0]  = pwr[k][1];
                    pst[k][0]  = pst[k][1];
                    padr[k][0] = padr[k][1];
                    pdat[k][0] = pdat[k][1];
                    pcnt[k]--;
                end
                if (req && e_aok) begin
                    due = mcyc + lat_of(k);
                    if (last_due[k] + 1 > due) due = last_due[k] + 1;
                    pdue[k][pcnt[k]] = due;
                    pwr[k][pcnt[k]]  = wr;
                    pst[k][pcnt[k]]  = wstrb;
                    padr[k][pcnt[k]] = addr;
                    pdat[k][pcnt[k]] = wdata;
                    pcnt[k]++;
                    last_due[k] = due;
                end
            end
        end
        mcyc++;
    end

    task automatic tick(input logic rst, input logic r, input logic w, input logic [1:0] sz,
                        input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        reset = rst; req = r; wr = w; size = sz; wstrb = st; addr = a; wdata = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, SIZE_WORD, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          input logic [1:0] sz);
        tick(1'b0, 1'b1, 1'b1, sz, st, a, d);
    endtask

    task automatic rd_req(input logic [31:0] a);
        tick(1'b0, 1'b1, 1'b0, SIZE_WORD, 4'h0, a, 32'h0);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    initial begin
        // Reset held: every output low on every instance.
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 1'b0, 1'b0, SIZE_WORD, 4'h0, 32'h0, 32'h0);
            for (int k = 0; k < NI; k++) begin
                chk_bit("rst_addr_ok", aok[k], 1'b0);
                chk_bit("rst_data_ok", dok[k], 1'b0);
                chk("rst_rdata", rdv[k], 32'h0);
            end
        end
        idle(1);
        for (int k = 0; k < NI; k++) chk_bit("post_rst_addr_ok", aok[k], 1'b1);

        // Full-word write then read, LATENCY 2.
        wr_req(32'h10, 32'hAABBCCDD, 4'hF, SIZE_WORD);
        chk_bit("w1_aok", aok[0], 1'b1);
        chk_bit("w1_dok_t0", dok[0], 1'b0);
        idle(1);
        chk_bit("w1_dok_t1", dok[0], 1'b0);
        idle(1);
        chk_bit("w1_dok_t2", dok[0], 1'b1);
        chk("w1_rdata", rdv[0], 32'h0);
        rd_req(32'h10);
        chk_bit("r1_dok_t0", dok[0], 1'b0);
        idle(2);
        chk_bit("r1_dok_t2", dok[0], 1'b1);
        chk("r1_rdata", rdv[0], 32'hAABBCCDD);
        idle(6);

        // Byte-lane write queued right before a read of the same word.
        wr_req(32'h10, 32'h000000EE, 4'h1, SIZE_BYTE);
        rd_req(32'h10);
        idle(1);
        chk_bit("raw_w_dok", dok[0], 1'b1);
        idle(1);
        chk_bit("raw_r_dok", dok[0], 1'b1);
        chk("raw_rdata", rdv[0], 32'hAABBCCEE);
        idle(6);

        // Address wrap, then a write with no lanes enabled.
        wr_req(32'h1010, 32'h12345678, 4'hF, SIZE_WORD);
        idle(2);
        rd_req(32'h10);
        idle(2);
        chk("wrap_rdata", rdv[0], 32'h12345678);
        wr_req(32'h10, 32'hFFFFFFFF, 4'h0, SIZE_HALF);
        idle(2);
        chk_bit("strb0_dok", dok[0], 1'b1);
        chk("strb0_rdata", rdv[0], 32'h0);
        rd_req(32'h10);
        idle(2);
        chk("strb0_keep", rdv[0], 32'h12345678);
        idle(6);

        // Slow prefill so every instance holds the same words.
        for (int i = 0; i < 8; i++) begin
            wr_req(32'h100 + 32'(4 * i), 32'hA0A00000 | 32'(i), 4'hF, SIZE_WORD);
            idle(5);
        end

        // Back-to-back reads: LATENCY 1 instance never stalls.
        for (int i = 0; i < 8; i++) begin
            rd_req(32'h100 + 32'(4 * i));
            chk_bit("stream_aok", aok[1], 1'b1);
            chk_bit("stream_dok", dok[1], i > 0);
        end
        idle(1);
        chk_bit("stream_last_dok", dok[1], 1'b1);
        idle(8);

        // Back-to-back writes, each instance accepts what it can.
        for (int i = 0; i < 8; i++) wr_req(32'h100 + 32'(4 * i), 32'hB0B00000 | 32'(i), 4'hF, SIZE_WORD);
        idle(8);
        for (int i = 0; i < 8; i++) begin
            rd_req(32'h100 + 32'(4 * i));
            idle(5);
        end
        chk("stream_w_l1", mmem[1][64 + 7], 32'hB0B00007);

        // Three consecutive requests against LATENCY 4.
        rd_req(32'h100);
        chk_bit("l4_aok0", aok[2], 1'b1);
        rd_req(32'h104);
        chk_bit("l4_aok1", aok[2], 1'b1);
        rd_req(32'h108);
        chk_bit("l4_aok2", aok[2], 1'b0);
        idle(1);
        chk_bit("l4_aok3", aok[2], 1'b0);
        chk_bit("l4_dok3", dok[2], 1'b0);
        idle(1);
        chk_bit("l4_aok4", aok[2], 1'b0);
        chk_bit("l4_dok4", dok[2], 1'b1);
        idle(1);
        chk_bit("l4_aok5", aok[2], 1'b1);
        chk_bit("l4_dok5", dok[2], 1'b1);
        idle(8);

        // Reset while two reads are pending.
        rd_req(32'h100);
        rd_req(32'h104);
        for (int c = 0; c < 2; c++) begin
            tick(1'b1, 1'b0, 1'b0, SIZE_WORD, 4'h0, 32'h0, 32'h0);
            chk_bit("mid_rst_dok", dok[2], 1'b0);
        end
        idle(1);
        chk_bit("mid_rst_release_aok", aok[2], 1'b1);
        chk_bit("mid_rst_release_dok", dok[2], 1'b0);
        for (int c = 0; c < 5; c++) begin
            idle(1);
            chk_bit("mid_rst_no_dok", dok[2], 1'b0);
        end

        // Memory contents survive reset.
        rd_req(32'h10);
        idle(2);
        chk("mem_after_rst", rdv[0], 32'h12345678);
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsram_responder.md
DSRAM_RESPONDER -- requirements
Module: dsram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving word-address width (memory depth 2^ADDR_W 32-bit words).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the minimum number of cycles from request acceptance to data_ok; legal range is 1..15.
REQ-003 The block SHALL have port clk, input, width 1, the clock.
REQ-004 The block SHALL have port reset, input, width 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port req, input, width 1: request valid from the CPU.
REQ-006 The block SHALL have port wr, input, width 1: 1 means write, 0 means read.
REQ-007 The block SHALL have port size, input, width 2: 0 means byte, 1 means half, 2 means word; the block records it only.
REQ-008 The block SHALL have port wstrb, input, width 4: byte-lane write enables.
REQ-009 The block SHALL have port addr, input, width 32: byte address.
REQ-010 The block SHALL have port wdata, input, width 32: write data.
REQ-011 The block SHALL have port addr_ok, output, width 1: request accepted in this cycle when req is also high.
REQ-012 The block SHALL have port data_ok, output, width 1: one-cycle completion pulse for the oldest pending transaction.
REQ-013 The block SHALL have port rdata, output, width 32: read data, valid only while data_ok is high.

Function
REQ-014 addr_ok SHALL be 1 exactly when the pending-request queue (depth 2) holds fewer than 2 entries; it SHALL depend only on registered state, never on req.
REQ-015 A request SHALL be accepted in every cycle where req and addr_ok are both high; wr, size, wstrb, addr and wdata SHALL be captured into the queue at that edge.
REQ-016 When the queue is full, a request SHALL NOT be accepted even if data_ok pops an entry in the same cycle.
REQ-017 Transactions SHALL complete strictly in acceptance order, with exactly one data_ok pulse per accepted transaction.
REQ-018 A transaction accepted in cycle T SHALL raise data_ok in cycle max(T+LATENCY, P+1), where P is the cycle of the previous transaction's data_ok.
REQ-019 The head-of-queue wait SHALL be tracked by a 4-bit counter; the counter SHALL restart on each new head.
REQ-020 The control FSM SHALL have state EMPTY (queue empty) and state BUSY (at least one entry pending).
REQ-021 The FSM SHALL move EMPTY->BUSY on acceptance.
REQ-022 The FSM SHALL move BUSY->EMPTY on a data_ok that pops the last entry when no acceptance occurs in the same cycle; otherwise it SHALL stay in BUSY.
REQ-023 The word index SHALL be addr[ADDR_W+1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-024 For a read, rdata in the data_ok cycle SHALL be the memory word at the word index, including all writes completed earlier; size and addr[1:0] SHALL NOT alter it (the CPU extracts the bytes).
REQ-025 For a write, byte lane i SHALL be updated with wdata[8i+7:8i] where wstrb[i]=1, at the edge ending the data_ok cycle.
REQ-026 rdata SHALL be 0 during a write's data_ok cycle and whenever data_ok is 0.
REQ-027 A write with wstrb=0 SHALL still produce data_ok and SHALL leave memory unchanged.
REQ-028 Read-after-write to the same word, both queued, SHALL return the new data.

Reset
REQ-029 While reset is high, addr_ok SHALL be 0, data_ok SHALL be 0, rdata SHALL be 0, the queue SHALL be empty, the counter SHALL be 0 and the FSM SHALL be in EMPTY.
REQ-030 Reset asserted mid-operation SHALL discard pending transactions with no data_ok; un-committed writes SHALL be lost.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 addr_ok SHALL return to 1 in the first cycle after reset deasserts.

Structure
REQ-033 The shared package SHALL hold the size encodings SIZE_BYTE/HALF/WORD, the queue-entry field widths and the FSM state encoding.
REQ-034 The queue SHALL be a sub-module, dsram_req_fifo: depth 2, with push/pop/full/empty ports and simultaneous push+pop supported.

Verification
REQ-035 With LATENCY=2, a write at cycle 5 of addr=0x10, wdata=0xAABBCCDD, wstrb=0xF SHALL produce data_ok in cycle 7; a read of 0x10 at cycle 8 SHALL return data_ok with rdata=0xAABBCCDD in cycle 10.
REQ-036 Writing 0x000000EE with wstrb=0x1 to a word holding 0xAABBCCDD SHALL cause a subsequent read to return 0xAABBCCEE.
REQ-037 Holding req=1 every cycle with LATENCY=1 SHALL keep addr_ok=1 every cycle and produce one data_ok per cycle after the first.
REQ-038 With LATENCY=4, three back-to-back requests SHALL accept the first two, drop addr_ok until the first data_ok, and keep the data_ok pulses in order.
REQ-039 Reset asserted while two reads are pending SHALL produce no data_ok and SHALL bring addr_ok=1 in the first cycle after release.
REQ-040 With ADDR_W=10, a write to 0x1010 followed by a read of 0x0010 SHALL return the written data (wrap-around).
